// File: rtl/prbs_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_ber_checker
// Purpose  : Bit-error-rate checker for one equalizer branch (I or Q). The
//            sign of each sliced symbol is the received bit. A local PRBS9
//            (x^9 + x^5 + 1) self-synchronises to the stream, lock is
//            qualified over a window, and bit, error and lock-loss counts
//            are accumulated for software readout.
// Ports    : clk          - system clock, rising edge
//            i_reset      - synchronous active-low reset (0 = reset)
//            i_is_data    - sliced symbol, signed; MSB is the received bit
//            i_en_rate1   - symbol strobe, one clk wide
//            i_en_rx      - global enable; 0 freezes all state
//            i_clear      - clears bit, error and loss counters
//            o_lock       - 1 while LOCKED
//            o_bit_count  - symbols checked while LOCKED (saturating)
//            o_err_count  - mismatches while LOCKED (saturating)
//            o_loss_count - LOCKED -> LOAD transitions (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module prbs_ber_checker #(
    parameter int NBT_IN     = 12,
    parameter int NB_CNT     = 64,
    parameter int NB_LOSS    = 8,
    parameter int WIN_LEN    = 511,
    parameter int LOCK_THR   = 2,
    parameter int UNLOCK_THR = 64
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic [NBT_IN-1:0]   i_is_data,
    input  logic                i_en_rate1,
    input  logic                i_en_rx,
    input  logic                i_clear,
    output logic                o_lock,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count,
    output logic [NB_LOSS-1:0]  o_loss_count
);

    // Window counters are wide enough to hold the window length and both
    // thresholds, so the threshold compares never truncate.
    localparam int c_WIN_W = $clog2(WIN_LEN + LOCK_THR + UNLOCK_THR + 1);

    localparam logic [c_WIN_W-1:0] c_WIN_LAST   = c_WIN_W'(WIN_LEN - 1);
    localparam logic [c_WIN_W-1:0] c_LOCK_THR   = c_WIN_W'(LOCK_THR);
    localparam logic [c_WIN_W-1:0] c_UNLOCK_THR = c_WIN_W'(UNLOCK_THR);
    localparam logic [3:0]         c_LOAD_LAST  = 4'd8;

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_CHECK  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]          r_state_q,    w_state_d;
    logic [8:0]          r_lfsr_q,     w_lfsr_d;
    logic [3:0]          r_load_cnt_q, w_load_cnt_d;
    logic [c_WIN_W-1:0]  r_win_cnt_q,  w_win_cnt_d;
    logic [c_WIN_W-1:0]  r_win_err_q,  w_win_err_d;
    logic [NB_CNT-1:0]   r_bit_cnt_q,  w_bit_cnt_d;
    logic [NB_CNT-1:0]   r_err_cnt_q,  w_err_cnt_d;
    logic [NB_LOSS-1:0]  r_loss_cnt_q, w_loss_cnt_d;

    logic                w_strobe;
    logic                w_rx_bit;
    logic                w_pred;
    logic                w_mismatch;
    logic                w_win_end;
    logic [c_WIN_W-1:0]  w_win_err_inc;

    // Only the sign bit carries information; the magnitude is ignored.
    logic                w_unused_data;
    assign w_unused_data = ^i_is_data[NBT_IN-2:0];

    always_comb begin
        w_state_d     = r_state_q;
        w_lfsr_d      = r_lfsr_q;
        w_load_cnt_d  = r_load_cnt_q;
        w_win_cnt_d   = r_win_cnt_q;
        w_win_err_d   = r_win_err_q;
        w_bit_cnt_d   = r_bit_cnt_q;
        w_err_cnt_d   = r_err_cnt_q;
        w_loss_cnt_d  = r_loss_cnt_q;

        w_strobe      = i_en_rx & i_en_rate1;
        w_rx_bit      = i_is_data[NBT_IN-1];
        // s[8] is the bit 9 symbols ago, s[4] the bit 5 symbols ago.
        w_pred        = r_lfsr_q[8] ^ r_lfsr_q[4];
        w_mismatch    = w_rx_bit ^ w_pred;
        w_win_err_inc = r_win_err_q + {{(c_WIN_W-1){1'b0}}, w_mismatch};
        w_win_end     = (r_win_cnt_q == c_WIN_LAST);

        if (w_strobe) begin
            case (r_state_q)
                c_ST_LOAD: begin
                    // Seed the LFSR straight from the received bits.
                    w_lfsr_d = {r_lfsr_q[7:0], w_rx_bit};
                    if (r_load_cnt_q == c_LOAD_LAST) begin
                        w_state_d    = c_ST_CHECK;
                        w_load_cnt_d = '0;
                        w_win_cnt_d  = '0;
                        w_win_err_d  = '0;
                    end else begin
                        w_load_cnt_d = r_load_cnt_q + 4'd1;
                    end
                end

                c_ST_CHECK, c_ST_LOCKED: begin
                    // Free-run on the prediction so a bit error in the
                    // stream costs exactly one mismatch.
                    w_lfsr_d = {r_lfsr_q[7:0], w_pred};

                    if (r_state_q == c_ST_LOCKED) begin
                        if (r_bit_cnt_q != '1) begin
                            w_bit_cnt_d = r_bit_cnt_q + 1'b1;
                        end
                        if (w_mismatch && (r_err_cnt_q != '1)) begin
                            w_err_cnt_d = r_err_cnt_q + 1'b1;
                        end
                    end

                    if (w_win_end) begin
                        w_win_cnt_d = '0;
                        w_win_err_d = '0;
                        if (r_state_q == c_ST_CHECK) begin
                            if (w_win_err_inc <= c_LOCK_THR) begin
                                w_state_d = c_ST_LOCKED;
                            end else begin
                                w_state_d    = c_ST_LOAD;
                                w_load_cnt_d = '0;
                            end
                        end else if (w_win_err_inc > c_UNLOCK_THR) begin
                            w_state_d    = c_ST_LOAD;
                            w_load_cnt_d = '0;
                            if (r_loss_cnt_q != '1) begin
                                w_loss_cnt_d = r_loss_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        w_win_cnt_d = r_win_cnt_q + {{(c_WIN_W-1){1'b0}}, 1'b1};
                        w_win_err_d = w_win_err_inc;
                    end
                end

                default: begin
                    w_state_d    = c_ST_LOAD;
                    w_load_cnt_d = '0;
                end
            endcase
        end

        // Clear beats a coincident increment; state and window are untouched.
        // A disabled receiver freezes everything, including the counters.
        if (i_en_rx && i_clear) begin
            w_bit_cnt_d  = '0;
            w_err_cnt_d  = '0;
            w_loss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_state_q    <= c_ST_LOAD;
            r_lfsr_q     <= '0;
            r_load_cnt_q <= '0;
            r_win_cnt_q  <= '0;
            r_win_err_q  <= '0;
            r_bit_cnt_q  <= '0;
            r_err_cnt_q  <= '0;
            r_loss_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_lfsr_q     <= w_lfsr_d;
            r_load_cnt_q <= w_load_cnt_d;
            r_win_cnt_q  <= w_win_cnt_d;
            r_win_err_q  <= w_win_err_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_err_cnt_q  <= w_err_cnt_d;
            r_loss_cnt_q <= w_loss_cnt_d;
        end
    end

    assign o_lock       = (r_state_q == c_ST_LOCKED);
    assign o_bit_count  = r_bit_cnt_q;
    assign o_err_count  = r_err_cnt_q;
    assign o_loss_count = r_loss_cnt_q;

endmodule
`default_nettype wire
